count_sequencer: RTL

Run controller for the 8-bit toggle-flip-flop counter. On a start command it clears the counter, issues one enable pulse every `TICK_DIV` clocks until the counter value equals a programmable target, then reports done. It sits between the switch/key front end and the counter: it drives the counter's clear and enable and watches its value.

---
 rtl/count_sequencer.sv | 85 ++++++++
 1 files changed

// File: rtl/count_sequencer.sv
// Run controller for the 8-bit counter: clear, prescaled enables, stop at target.
// Define COUNT_SEQUENCER_AUTORELOAD_EN for back-to-back runs with a one-cycle done.
module count_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clock,
    input  logic       clearb,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] target,
    input  logic [7:0] cnt_value,
    output logic       cnt_enable,
    output logic       cnt_clear,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic          hit;
    logic          tick;

    always_ff @(posedge clock or posedge clearb) begin
        if (clearb) begin
            cur <= IDLE;
            pre <= '0;
        end else begin
            cur <= nxt;
            pre <= pre_nxt;
        end
    end

    always_comb begin
        nxt        = cur;
        pre_nxt    = '0;
        cnt_enable = 1'b0;
        cnt_clear  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        hit        = (cnt_value == target);
        tick       = (pre == LAST);
        unique case (cur)
            IDLE: begin
                if (!stop && start) nxt = CLEAR;
            end
            CLEAR: begin
                cnt_clear = 1'b1;
                busy      = 1'b1;
                nxt       = stop ? IDLE : RUN;
            end
            RUN: begin
                busy       = 1'b1;
                pre_nxt    = tick ? '0 : pre + PW'(1);
                cnt_enable = tick && !hit && !stop;
                if (stop)     nxt = IDLE;
                else if (hit) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
                nxt = stop ? IDLE : CLEAR;
`else
                if (stop)       nxt = IDLE;
                else if (start) nxt = CLEAR;
`endif
            end
        endcase
    end

    assign state = cur;

endmodule
